// File: rtl/bram_uart_dump_if.sv
// rtl/bram_uart_dump_if.sv - request, BRAM read port and UART line bundle for bram_uart_dump
interface bram_uart_dump_if;
  logic       dump_start;
  logic [9:0] bram_rd_addr;
  logic [7:0] bram_rd_data;
  logic       uart_tx;
  logic       busy;
  logic       done;

  modport master (
    output dump_start,
    output bram_rd_data,
    input  bram_rd_addr,
    input  uart_tx,
    input  busy,
    input  done
  );

  modport slave (
    input  dump_start,
    input  bram_rd_data,
    output bram_rd_addr,
    output uart_tx,
    output busy,
    output done
  );
endinterface

// File: rtl/bram_uart_dump.sv
// rtl/bram_uart_dump.sv - sequential BRAM readback onto a UART 8N1 line
// Optional trailing checksum frame: define DUMP_CHECKSUM_EN.
module bram_uart_dump #(
  parameter int CLK_FREQ  = 32'd50_000_000,
  parameter int BAUD      = 115200,
  parameter int IMG_BYTES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  bram_uart_dump_if.slave  bus
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [10:0] LAST_IDX = 11'(IMG_BYTES - 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, WAIT, START, DATA, STOP,
`ifdef DUMP_CHECKSUM_EN
    CSUM,
`endif
    FIN
  } state_t;

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [10:0]   index;
  logic [7:0]    shift;
  logic          tx;
  logic          busy_r;
  logic          done_r;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]    sum;
  logic          in_csum;
`endif

  wire baud_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      index    <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      sum      <= '0;
      in_csum  <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.dump_start) begin
            index  <= '0;
            busy_r <= 1'b1;
            state  <= ADDR;
`ifdef DUMP_CHECKSUM_EN
            sum     <= '0;
            in_csum <= 1'b0;
`endif
          end
        end
        ADDR: state <= WAIT;
        WAIT: begin
          shift    <= bus.bram_rd_data;
          tx       <= 1'b0;
          baud_cnt <= '0;
          state    <= START;
`ifdef DUMP_CHECKSUM_EN
          sum <= sum + bus.bram_rd_data;
`endif
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
`ifdef DUMP_CHECKSUM_EN
            if (in_csum) begin
              busy_r <= 1'b0;
              done_r <= 1'b1;
              state  <= FIN;
            end else if (index < LAST_IDX) begin
              index <= index + 11'd1;
              state <= ADDR;
            end else begin
              state <= CSUM;
            end
`else
            if (index < LAST_IDX) begin
              index <= index + 11'd1;
              state <= ADDR;
            end else begin
              busy_r <= 1'b0;
              done_r <= 1'b1;
              state  <= FIN;
            end
`endif
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef DUMP_CHECKSUM_EN
        // Two idle cycles stand in for ADDR/WAIT so the gap matches data frames.
        CSUM: begin
          if (baud_cnt == BW'(1)) begin
            baud_cnt <= '0;
            shift    <= sum;
            tx       <= 1'b0;
            in_csum  <= 1'b1;
            state    <= START;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bram_rd_addr = index[9:0];
  assign bus.uart_tx      = tx;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
endmodule

// File: tb/tb_bram_uart_dump.sv
// tb/tb_bram_uart_dump.sv - directed self-checking bench for bram_uart_dump
module tb_bram_uart_dump;
  localparam int CF = 1_000_000;
  localparam int BD = 100_000;
  localparam int C  = 10;
`ifdef DUMP_CHECKSUM_EN
  localparam int NB16    = 17;
  localparam int DONE_K1 = (2 + 10*C) + (2 + 10*C);
`else
  localparam int NB16    = 16;
  localparam int DONE_K1 = 2 + 10*C;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_uart_dump_if if1();
  bram_uart_dump_if if16();

  bram_uart_dump #(.CLK_FREQ(CF), .BAUD(BD), .IMG_BYTES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );
  bram_uart_dump #(.CLK_FREQ(CF), .BAUD(BD), .IMG_BYTES(16)) dut16 (
    .clk(clk), .rst(rst), .bus(if16)
  );

  // Registered-read BRAM models: one cycle from address to data.
  always @(posedge clk) begin
    if1.bram_rd_data  <= (if1.bram_rd_addr == 10'd0) ? 8'hA5 : 8'h00;
    if16.bram_rd_data <= 8'(if16.bram_rd_addr);
  end

  int passed = 0;
  int total  = 0;

  logic [7:0] rx [32];
  int nb, gap_bad, addr_bad, ndone;
  bit timeout;
  logic rst_tx, rst_busy;
  logic [9:0] rst_addr;

  task automatic capture16(input bit pulse5, input bit rst3);
    int t, run, prev, after_done;
    bit fin;
    logic [7:0] sh;
    nb = 0; gap_bad = 0; addr_bad = 0; ndone = 0; timeout = 0;
    t = -1; run = 0; after_done = -1; fin = 0; sh = '0;
    @(negedge clk) if16.dump_start = 1'b1;
    @(negedge clk) if16.dump_start = 1'b0;
    prev = int'(if16.bram_rd_addr);
    if (prev != 0) addr_bad++;
    for (int k = 1; k < 4000 && !fin; k++) begin
      @(negedge clk);
      if16.dump_start = 1'b0;
      if (int'(if16.bram_rd_addr) != prev) begin
        if (int'(if16.bram_rd_addr) != prev + 1) addr_bad++;
        prev = int'(if16.bram_rd_addr);
      end
      if (if16.done === 1'b1) begin
        ndone++;
        if (after_done < 0) after_done = k;
      end
      if (t < 0) begin
        if (if16.uart_tx === 1'b0) begin
          t = 0;
          if (nb > 0 && run != 12) gap_bad++;
        end else begin
          run++;
        end
      end else begin
        t++;
        if (t >= 15 && t <= 85 && (t % 10) == 5) sh[(t-15)/10] = if16.uart_tx;
        if (t == 95) begin
          if (if16.uart_tx !== 1'b1) gap_bad++;
          if (nb < 32) rx[nb] = sh;
          nb++;
          t = -1;
          run = 6;
        end
      end
      if (pulse5 && nb == 5 && t == 30) if16.dump_start = 1'b1;
      if (after_done >= 0 && k >= after_done + 150) fin = 1;
      if (rst3 && nb == 3 && t == 40) begin
        rst = 1'b1;
        @(negedge clk);
        rst_tx = if16.uart_tx; rst_busy = if16.busy; rst_addr = if16.bram_rd_addr;
        rst = 1'b0;
        fin = 1;
      end
    end
    timeout = !fin;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; if1.dump_start = 1'b0; if16.dump_start = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (if16.uart_tx !== 1'b1) $display("FAIL reset_tx got %b want 1", if16.uart_tx); else passed++;
    total++; if (if16.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", if16.busy); else passed++;
    total++; if (if16.done !== 1'b0) $display("FAIL reset_done got %b want 0", if16.done); else passed++;
    total++; if (if16.bram_rd_addr !== 10'd0) $display("FAIL reset_addr got %0d want 0", if16.bram_rd_addr); else passed++;
    total++; if (if1.uart_tx !== 1'b1 || if1.busy !== 1'b0) $display("FAIL reset_dut1 got tx=%b busy=%b want 1/0", if1.uart_tx, if1.busy); else passed++;
    rst = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (if16.uart_tx !== 1'b1 || if16.busy !== 1'b0 || if16.done !== 1'b0 || if16.bram_rd_addr !== 10'd0) bad++;
      if (if1.uart_tx !== 1'b1 || if1.busy !== 1'b0 || if1.done !== 1'b0) bad++;
    end
    total++; if (bad != 0) $display("FAIL idle_stable got %0d bad cycles want 0", bad); else passed++;
  endtask

  task automatic test_single_byte();
    logic pat [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int line_bad, done_bad, fall_k;
    logic exp_tx, busy_at_done;
    line_bad = 0; done_bad = 0; fall_k = -1; busy_at_done = 1'bx;
    @(negedge clk) if1.dump_start = 1'b1;
    @(negedge clk) if1.dump_start = 1'b0;
    total++; if (if1.busy !== 1'b1 || if1.bram_rd_addr !== 10'd0) $display("FAIL accept got busy=%b addr=%0d want 1/0", if1.busy, if1.bram_rd_addr); else passed++;
    for (int k = 1; k <= DONE_K1 + 1; k++) begin
      @(negedge clk);
      exp_tx = (k < 2) ? 1'b1 : pat[(k-2)/10];
      if (k <= 101 && if1.uart_tx !== exp_tx) line_bad++;
      if (fall_k < 0 && if1.uart_tx === 1'b0) fall_k = k;
      if (if1.done !== (k == DONE_K1)) done_bad++;
      if (k == DONE_K1) busy_at_done = if1.busy;
    end
    total++; if (fall_k != 2) $display("FAIL tx_fall got %0d want 2", fall_k); else passed++;
    total++; if (line_bad != 0) $display("FAIL frame_a5 got %0d bad cycles want 0", line_bad); else passed++;
    total++; if (done_bad != 0) $display("FAIL done_pulse got %0d bad cycles want 0", done_bad); else passed++;
    total++; if (busy_at_done !== 1'b0) $display("FAIL busy_at_done got %b want 0", busy_at_done); else passed++;
    total++; if (if1.busy !== 1'b0 || if1.uart_tx !== 1'b1) $display("FAIL after_done got busy=%b tx=%b want 0/1", if1.busy, if1.uart_tx); else passed++;
  endtask

  task automatic test_sequential();
    capture16(1'b0, 1'b0);
    total++; if (timeout) $display("FAIL seq_timeout got 1 want 0"); else passed++;
    total++; if (nb != NB16) $display("FAIL seq_count got %0d want %0d", nb, NB16); else passed++;
    for (int i = 0; i < 16; i++) begin
      total++; if (rx[i] !== 8'(i)) $display("FAIL seq_byte%0d got %h want %h", i, rx[i], 8'(i)); else passed++;
    end
`ifdef DUMP_CHECKSUM_EN
    total++; if (rx[16] !== 8'h78) $display("FAIL checksum got %h want 78", rx[16]); else passed++;
`endif
    total++; if (gap_bad != 0) $display("FAIL seq_gaps got %0d bad want 0", gap_bad); else passed++;
    total++; if (addr_bad != 0) $display("FAIL seq_addr got %0d bad steps want 0", addr_bad); else passed++;
    total++; if (if16.bram_rd_addr !== 10'd15) $display("FAIL seq_last_addr got %0d want 15", if16.bram_rd_addr); else passed++;
    total++; if (ndone != 1) $display("FAIL seq_done got %0d want 1", ndone); else passed++;
  endtask

  task automatic test_busy_ignore();
    int bad;
    capture16(1'b1, 1'b0);
    bad = 0;
    for (int i = 0; i < 16; i++) if (rx[i] !== 8'(i)) bad++;
    total++; if (nb != NB16 || timeout) $display("FAIL ignore_count got %0d want %0d", nb, NB16); else passed++;
    total++; if (ndone != 1) $display("FAIL ignore_done got %0d want 1", ndone); else passed++;
    total++; if (bad != 0 || addr_bad != 0) $display("FAIL ignore_data got %0d/%0d bad want 0/0", bad, addr_bad); else passed++;
  endtask

  task automatic test_reset_mid();
    int bad;
    capture16(1'b0, 1'b1);
    total++; if (rst_tx !== 1'b1) $display("FAIL midrst_tx got %b want 1", rst_tx); else passed++;
    total++; if (rst_busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", rst_busy); else passed++;
    total++; if (rst_addr !== 10'd0) $display("FAIL midrst_addr got %0d want 0", rst_addr); else passed++;
    repeat (5) @(negedge clk);
    capture16(1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < 16; i++) if (rx[i] !== 8'(i)) bad++;
    total++; if (nb != NB16 || timeout) $display("FAIL redump_count got %0d want %0d", nb, NB16); else passed++;
    total++; if (bad != 0 || addr_bad != 0 || ndone != 1) $display("FAIL redump_data got %0d/%0d/%0d want 0/0/1", bad, addr_bad, ndone); else passed++;
  endtask

  initial begin
    if1.dump_start  = 1'b0;
    if16.dump_start = 1'b0;
    test_reset();
    test_single_byte();
    test_sequential();
    test_busy_ignore();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
